// File: rtl/pb_conditioner_if.sv
// Pushbutton conditioner bus: raw levels in, conditioned button state out.
interface pb_conditioner_if #(
  parameter int NUM_PB = 15
);
  logic [NUM_PB-1:0] pb_raw;
  logic [NUM_PB-1:0] pb_clean;
  logic [NUM_PB-1:0] pb_rise;
  logic              key_valid;
  logic [3:0]        key_idx;
  logic              key_strobe;
  logic [1:0]        mode;

  // Board side: drives raw buttons, consumes conditioned outputs.
  modport master (
    output pb_raw,
    input  pb_clean, pb_rise, key_valid, key_idx, key_strobe, mode
  );

  // Conditioner side.
  modport slave (
    input  pb_raw,
    output pb_clean, pb_rise, key_valid, key_idx, key_strobe, mode
  );
endinterface

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, tick-sampled debouncer,
// rising-edge pulses, note-key priority encoder and 2-bit mode counter.
// The top bit is the mode button; all lower bits are note keys.
module pb_conditioner #(
  parameter int NUM_PB         = 15,
  parameter int TICK_DIV       = 10000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  pb_conditioner_if.slave bus
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NK    = NUM_PB - 1;

  logic [NUM_PB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [NUM_PB-1:0][STABLE_SAMPLES-1:0] hist_q, hist_d;
  logic [NUM_PB-1:0] clean_q, clean_d, clean_dly_q, clean_dly_d;
  logic [NUM_PB-1:0] rise_q, rise_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_idx_q, key_idx_d;
  logic              key_strobe_q, key_strobe_d;
  logic [1:0]        mode_q, mode_d;

  // Synchronizer chain and shared sample-tick divider.
  always_comb begin
    sync1_d = bus.pb_raw;
    sync2_d = sync1_q;
    tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
  end

  // Shift histories on tick; a full run of equal samples sets the clean level.
  always_comb begin
    hist_d  = hist_q;
    clean_d = clean_q;
    if (tick) begin
      for (int i = 0; i < NUM_PB; i++) begin
        hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        if (&hist_d[i]) begin
          clean_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          clean_d[i] = 1'b0;
        end
      end
    end
  end

  // Edge pulses, lowest-index key priority encoder, strobe and mode counter.
  always_comb begin
    clean_dly_d  = clean_q;
    rise_d       = clean_q & ~clean_dly_q;
    key_valid_d  = |clean_q[NK-1:0];
    key_idx_d    = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (clean_q[i]) key_idx_d = 4'(i);
    end
    key_strobe_d = |rise_q[NK-1:0];
    mode_d       = mode_q + {1'b0, rise_q[NK]};
  end

  // State registers; reset discards all debounce history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      hist_q       <= '0;
      clean_q      <= '0;
      clean_dly_q  <= '0;
      rise_q       <= '0;
      key_valid_q  <= 1'b0;
      key_idx_q    <= '0;
      key_strobe_q <= 1'b0;
      mode_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      hist_q       <= hist_d;
      clean_q      <= clean_d;
      clean_dly_q  <= clean_dly_d;
      rise_q       <= rise_d;
      key_valid_q  <= key_valid_d;
      key_idx_q    <= key_idx_d;
      key_strobe_q <= key_strobe_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.pb_clean   = clean_q;
  assign bus.pb_rise    = rise_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_idx    = key_idx_q;
  assign bus.key_strobe = key_strobe_q;
  assign bus.mode       = mode_q;
endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_pb_conditioner;
  localparam int NUM_PB = 15;
  localparam int TDIV   = 4;
  localparam int SSAMP  = 3;
  localparam int LAT_MIN = 2 + (SSAMP - 1) * TDIV + 1;
  localparam int LAT_MAX = 2 + SSAMP * TDIV;

  logic clk;
  logic n_rst;
  pb_conditioner_if #(.NUM_PB(NUM_PB)) bus ();

  pb_conditioner #(
    .NUM_PB(NUM_PB), .TICK_DIV(TDIV), .STABLE_SAMPLES(SSAMP)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse/event counters sampled mid-cycle.
  int       rise_total = 0;
  int       rise0_total = 0;
  int       strobe_total = 0;
  int       mode_changes = 0;
  logic [1:0] prev_mode = 2'd0;
  always @(negedge clk) begin
    rise_total   <= rise_total + $countones(bus.pb_rise);
    rise0_total  <= rise0_total + int'(bus.pb_rise[0]);
    strobe_total <= strobe_total + int'(bus.key_strobe);
    if (bus.mode !== prev_mode) mode_changes <= mode_changes + 1;
    prev_mode <= bus.mode;
  end

  typedef struct {
    logic [14:0] raw;
    logic [14:0] clean;
    int          kv;
    int          idx;
    int          mode;
    int          rises;
    int          strobes;
  } vec_t;

  vec_t tbl [18];

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clean"},  int'(bus.pb_clean), 0);
    chk({tag, "_rise"},   int'(bus.pb_rise), 0);
    chk({tag, "_kv"},     int'(bus.key_valid), 0);
    chk({tag, "_idx"},    int'(bus.key_idx), 0);
    chk({tag, "_strobe"}, int'(bus.key_strobe), 0);
    chk({tag, "_mode"},   int'(bus.mode), 0);
  endtask

  initial begin
    int n;
    int r0, s0, m0;
    bit bad;

    tbl[0]  = '{15'h0020, 15'h0020, 1, 5,  0, 1, 1};
    tbl[1]  = '{15'h0000, 15'h0000, 0, 0,  0, 0, 0};
    tbl[2]  = '{15'h0080, 15'h0080, 1, 7,  0, 1, 1};
    tbl[3]  = '{15'h0088, 15'h0088, 1, 3,  0, 1, 1};
    tbl[4]  = '{15'h0080, 15'h0080, 1, 7,  0, 0, 0};
    tbl[5]  = '{15'h2001, 15'h2001, 1, 0,  0, 2, 1};
    tbl[6]  = '{15'h2000, 15'h2000, 1, 13, 0, 0, 0};
    tbl[7]  = '{15'h0000, 15'h0000, 0, 0,  0, 0, 0};
    tbl[8]  = '{15'h4000, 15'h4000, 0, 0,  1, 1, 0};
    tbl[9]  = '{15'h0000, 15'h0000, 0, 0,  1, 0, 0};
    tbl[10] = '{15'h4000, 15'h4000, 0, 0,  2, 1, 0};
    tbl[11] = '{15'h0000, 15'h0000, 0, 0,  2, 0, 0};
    tbl[12] = '{15'h4000, 15'h4000, 0, 0,  3, 1, 0};
    tbl[13] = '{15'h0000, 15'h0000, 0, 0,  3, 0, 0};
    tbl[14] = '{15'h4000, 15'h4000, 0, 0,  0, 1, 0};
    tbl[15] = '{15'h0000, 15'h0000, 0, 0,  0, 0, 0};
    tbl[16] = '{15'h4000, 15'h4000, 0, 0,  1, 1, 0};
    tbl[17] = '{15'h0000, 15'h0000, 0, 0,  1, 0, 0};

    // Reset state
    n_rst = 1'b0;
    bus.pb_raw = '0;
    #2;
    chk_all_zero("reset");
    step(3);
    n_rst = 1'b1;
    step(5);
    chk_all_zero("post_reset");

    // Press latency on bit 5, single rise pulse
    bus.pb_raw[5] = 1'b1;
    n = 0;
    while (!bus.pb_clean[5] && n < 30) begin
      step();
      n++;
    end
    chk_range("press_latency", n, LAT_MIN, LAT_MAX);
    chk("press_rise_before", int'(bus.pb_rise[5]), 0);
    step();
    chk("press_rise_pulse", int'(bus.pb_rise[5]), 1);
    chk("press_kv", int'(bus.key_valid), 1);
    chk("press_idx", int'(bus.key_idx), 5);
    step();
    chk("press_rise_end", int'(bus.pb_rise[5]), 0);
    chk("press_strobe", int'(bus.key_strobe), 1);
    step();
    chk("press_strobe_end", int'(bus.key_strobe), 0);

    // Release latency on bit 5, no pulses
    r0 = rise_total;
    s0 = strobe_total;
    bus.pb_raw[5] = 1'b0;
    n = 0;
    while (bus.pb_clean[5] && n < 30) begin
      step();
      n++;
    end
    chk_range("release_latency", n, LAT_MIN, LAT_MAX);
    step(5);
    chk("release_no_rise", rise_total - r0, 0);
    chk("release_no_strobe", strobe_total - s0, 0);
    chk("release_kv", int'(bus.key_valid), 0);
    chk("release_idx", int'(bus.key_idx), 0);

    // Table of settled-state vectors
    for (int v = 0; v < 18; v++) begin
      r0 = rise_total;
      s0 = strobe_total;
      bus.pb_raw = tbl[v].raw;
      step(20);
      chk($sformatf("v%0d_clean", v), int'(bus.pb_clean), int'(tbl[v].clean));
      chk($sformatf("v%0d_kv", v), int'(bus.key_valid), tbl[v].kv);
      chk($sformatf("v%0d_idx", v), int'(bus.key_idx), tbl[v].idx);
      chk($sformatf("v%0d_mode", v), int'(bus.mode), tbl[v].mode);
      chk($sformatf("v%0d_rises", v), rise_total - r0, tbl[v].rises);
      chk($sformatf("v%0d_strobes", v), strobe_total - s0, tbl[v].strobes);
    end

    // Single-cycle glitch on bit 2
    r0 = rise_total;
    s0 = strobe_total;
    bad = 1'b0;
    step(1);
    bus.pb_raw[2] = 1'b1;
    step(1);
    bus.pb_raw[2] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.pb_clean[2]) bad = 1'b1;
    end
    chk("glitch_clean", int'(bad), 0);
    chk("glitch_rise", rise_total - r0, 0);
    chk("glitch_strobe", strobe_total - s0, 0);

    // Bounce on bit 0 then settle high
    r0 = rise0_total;
    for (int k = 0; k < 20; k++) begin
      bus.pb_raw[0] = ~bus.pb_raw[0];
      step();
    end
    bus.pb_raw[0] = 1'b1;
    step(30);
    chk("bounce_rise_count", rise0_total - r0, 1);
    chk("bounce_clean", int'(bus.pb_clean[0]), 1);
    bus.pb_raw[0] = 1'b0;
    step(20);
    chk("bounce_release", int'(bus.pb_clean[0]), 0);

    // Mode button held: one increment only
    m0 = mode_changes;
    bus.pb_raw[14] = 1'b1;
    step(100);
    chk("hold_mode", int'(bus.mode), 2);
    chk("hold_changes", mode_changes - m0, 1);
    bus.pb_raw[14] = 1'b0;
    step(20);
    chk("hold_release_mode", int'(bus.mode), 2);

    // Reset mid-operation with bit 4 held
    bus.pb_raw[4] = 1'b1;
    step(20);
    chk("pre_rst_clean", int'(bus.pb_clean), 16);
    chk("pre_rst_mode", int'(bus.mode), 2);
    n_rst = 1'b0;
    #2;
    chk_all_zero("mid_rst");
    step(2);
    n_rst = 1'b1;
    n = 0;
    while (!bus.pb_clean[4] && n < 30) begin
      step();
      n++;
    end
    chk_range("rst_requal_latency", n, LAT_MIN, LAT_MAX);
    step();
    chk("rst_rise_pulse", int'(bus.pb_rise[4]), 1);
    chk("rst_kv", int'(bus.key_valid), 1);
    chk("rst_idx", int'(bus.key_idx), 4);
    step();
    chk("rst_rise_end", int'(bus.pb_rise[4]), 0);
    chk("rst_mode", int'(bus.mode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
Conditions the raw breakout-board pushbuttons before they reach the synthesizer core. Each bit passes through a 2-flop synchronizer and a sampled debouncer, then gets a rising-edge detector. The block also priority-encodes the note keys and maintains the 2-bit mode counter advanced by the dedicated mode button. It sits directly upstream of the core, between gpio_in and the core's pushbutton/mode inputs.

Parameters:
NUM_PB, 15, total pushbuttons; bit NUM_PB-1 is the mode button; bits [NUM_PB-2:0] are note keys (NUM_PB-1 ≤ 16).
TICK_DIV, 10000, clock cycles per debounce sample tick (≥2); 1 ms at 10 MHz.
STABLE_SAMPLES, 4, consecutive equal samples required to change a clean level (≥2).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
pb_raw  in  NUM_PB  raw asynchronous pushbutton levels, active high
pb_clean  out  NUM_PB  debounced levels
pb_rise  out  NUM_PB  one-cycle pulse per debounced press
key_valid  out  1  at least one note key is held (debounced)
key_idx  out  4  index of the lowest-numbered held note key; 0 when key_valid=0
key_strobe  out  1  one-cycle pulse when any note key's pb_rise fires
mode  out  2  current mode, 0..3

Behaviour:
- Reset (async assert, sync release): sync flops, sample histories, tick counter, pb_clean, pb_rise, key_valid, key_idx, key_strobe and mode all go to 0 immediately.
- Synchronizer: 2 flops per bit. sync = pb_raw delayed 2 cycles.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. tick is high for exactly one cycle when count == TICK_DIV-1. After reset release, the first tick occurs on cycle TICK_DIV-1.
- Sample history: per bit, a STABLE_SAMPLES-deep shift register. It shifts in sync only on tick.
- Clean-level rule, evaluated on tick:
  - If the history including the new sample is all 1 → pb_clean=1.
  - If it is all 0 → pb_clean=0.
  - Otherwise pb_clean holds its value.
  - pb_clean changes only on the tick cycle's clock edge.
- Press latency (raw rise to pb_clean rise, input held steady):
  - Minimum 2 + (STABLE_SAMPLES-1)*TICK_DIV + 1 cycles.
  - Maximum 2 + STABLE_SAMPLES*TICK_DIV cycles.
  - Release latency uses the same bounds.
- pb_rise[i] is registered: high for exactly one cycle, the cycle after pb_clean[i] goes 0→1. There is no pulse on release.
- key_valid / key_idx are registered from pb_clean[NUM_PB-2:0], with 1 cycle of latency after pb_clean.
  - Lowest set index wins.
  - When no key is held: key_valid=0, key_idx=0.
- key_strobe = registered OR of pb_rise[NUM_PB-2:0], so it is 1 cycle after the pb_rise pulse. Multiple simultaneous rises produce a single one-cycle strobe.
- mode:
  - Increments on pb_rise[NUM_PB-1], becoming valid the following cycle.
  - Wraps 3→0; there is no saturation.
  - Holding the mode button does not auto-repeat.
- Boundaries:
  - A glitch shorter than one tick interval cannot change pb_clean unless it is captured on STABLE_SAMPLES consecutive ticks.
  - Bounce of any length produces at most one pb_rise once the input settles.
  - Reset mid-debounce discards all history. A button still held after release must re-qualify fully and then produces a fresh pb_rise.
  - All bits share one tick and are otherwise independent.

Test Plan:
- Use TICK_DIV=4, STABLE_SAMPLES=3 throughout. Per the latency bounds, pb_clean rises 11–14 cycles after the raw rise and pb_rise follows 1 cycle after that.
- Clean press: raise pb_raw[5] and hold → pb_clean[5] rises within the bounds; pb_rise[5] is a single 1-cycle pulse; key_valid=1, key_idx=5, key_strobe pulses once. Releasing → pb_clean[5]=0 with no pb_rise, then key_valid=0, key_idx=0.
- Glitch: pulse pb_raw[2] high for 1 cycle between ticks → pb_clean, pb_rise and key_strobe stay 0 for 40 cycles.
- Bounce: toggle pb_raw[0] every cycle for 20 cycles, then hold high → exactly one pb_rise[0] pulse and pb_clean[0]=1.
- Priority: hold pb_raw[7], then add pb_raw[3] → key_idx goes 7 then 3. Releasing bit 3 → key_idx=7. No key_strobe on releases.
- Mode: five debounced presses/releases of pb_raw[14] → mode sequence 1,2,3,0,1; final mode=1. Holding bit 14 for 100 cycles → only one increment.
- Reset mid-operation: with pb_clean[4]=1 and mode=2, pulse n_rst low while pb_raw[4] stays held → all outputs 0 asynchronously. After release, pb_rise[4] fires again within the latency bounds and mode=0.
